uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler that shares one uart_tx serializer between N_REQ byte producers
//  (ADC channels, status reporter). Latches the winner's byte, presents it to the
//  serializer, tracks tx_busy through the frame, then acks the requester. Sits between
//  the ADC sample/format logic and uart_tx; a watchdog recovers from a stalled serializer.
// PARAMETERS
//  N_REQ        4        number of requesters (2..8)
//  ID_W         2        grant index width, = clog2(N_REQ)
//  DATA_W       8        byte width, must equal uart_tx data width
//  TIMEOUT_CYC  200000   max RST_clk cycles in any WAIT state before abort
//  TAG_BASE     8'hA0    tag byte = TAG_BASE | grant index (UART_TX_SCHED_TAG_EN only)
// PORTS
//  RST_clk     in   1             system clock (50 MHz), all logic on rising edge
//  RST_n       in   1             reset, synchronous, active-low
//  req         in   N_REQ         request per producer, level, held until ack
//  req_data    in   N_REQ*DATA_W  byte of producer i at [i*DATA_W +: DATA_W]
//  ack         out  N_REQ         one-cycle pulse to producer whose byte finished
//  tx_data     out  DATA_W        byte to serializer, stable from LOAD until next LOAD
//  tx_start    out  1             one-cycle start strobe to serializer
//  tx_busy     in   1             serializer busy (uart_busy), RST_clk domain
//  grant_id    out  ID_W          index of current/last granted producer
//  sched_busy  out  1             high in every state except IDLE
//  timeout_err out  1             sticky; set on watchdog abort, cleared only by reset
// BEHAVIOUR
//  Reset (RST_n=0 at edge): state=IDLE; ack=0, tx_start=0, tx_data=0, grant_id=0,
//   sched_busy=0, timeout_err=0; rr pointer=N_REQ-1 so req[0] wins first. Reset
//   mid-frame aborts silently: no ack, serializer left to finish on its own.
//  IDLE: if |req, pick first set bit searching ptr+1, ptr+2 .. wrapping mod N_REQ;
//   latch index -> grant_id, ptr, byte -> hold reg; go LOAD. No req: stay.
//  LOAD: tx_data <= held byte (or tag, see CONFIGURATION); go START.
//  START: tx_start=1 for exactly this cycle; watchdog cleared; go WAIT_HI.
//  WAIT_HI: wait tx_busy=1 -> WAIT_LO. WAIT_LO: wait tx_busy=0 -> DONE.
//  DONE: if tag was sent and data still pending -> LOAD with data byte;
//   else ack[grant_id]=1 one cycle, go IDLE (earliest re-arbitration next cycle).
//  Watchdog: counter runs in WAIT_HI/WAIT_LO, reset on START; reaching TIMEOUT_CYC ->
//   timeout_err=1, no ack, go IDLE; ptr already advanced so requester is not starved
//   (it re-competes next round).
//  Only one frame in flight; tx_start never asserted while tx_busy=1 or outside START.
//  req dropped after grant: frame still sent and acked (byte latched at grant).
//  req asserted during ack cycle by same producer: treated as new request, but
//   round-robin serves all other pending requesters first.
//  Fairness: with all req high, grant order 0,1,..,N_REQ-1,0,...
//  Latency: IDLE with req -> tx_start = 3 cycles (IDLE, LOAD, START).
// CONFIGURATION
//  UART_TX_SCHED_TAG_EN defined: each grant sends two frames, tag byte
//   (TAG_BASE | grant_id) then data byte; single ack after second frame; watchdog per
//   frame. Undefined: one frame per grant, tag logic and TAG_BASE unused.
// TESTING
//  Bench serializer model: busy rises 2 cycles after tx_start, holds 10 cycles.
//  1 reset: RST_n=0 for 3 cycles with req=4'hF -> all outputs 0, no tx_start; first
//    grant after release is 0, tx_data=req_data[7:0].
//  2 single: req=4'b0100, byte 8'h5A -> tx_start 3 cycles later, tx_data=8'h5A,
//    ack=4'b0100 one cycle after busy falls, grant_id=2.
//  3 fairness: req=4'hF held, re-raise after each ack -> 8 grants order 0,1,2,3,0,1,2,3,
//    never two tx_start within one busy window.
//  4 timeout: TIMEOUT_CYC=50, model never raises busy -> after 50 cycles in WAIT_HI
//    timeout_err=1, no ack, back to IDLE, next request serviced normally.
//  5 reset mid-frame: RST_n=0 during WAIT_LO -> no ack, state IDLE, ptr reset to
//    N_REQ-1.
//  6 TAG_EN: req=4'b0010, byte 8'h33 -> frames 8'hA1 then 8'h33, exactly one ack.

Source files
------------

// File: rtl/uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one UART serializer between N_REQ
//            byte producers. The winning producer's byte is latched at grant,
//            presented to the serializer with a one-cycle start strobe, and
//            the frame is followed through tx_busy. The producer is then
//            acknowledged. A watchdog abandons a frame whose serializer never
//            raises or never drops busy.
// Optional : UART_TX_SCHED_TAG_EN - when defined, every grant sends a tag
//            frame (TAG_BASE | grant index) before the data frame. There is
//            one ack, after the data frame.
// Ports    : RST_clk     in   system clock, rising edge
//            RST_n       in   synchronous active-low reset
//            req         in   [N_REQ] level request per producer, held until ack
//            req_data    in   [N_REQ*DATA_W] byte i at [i*DATA_W +: DATA_W]
//            ack         out  [N_REQ] one-cycle pulse when a producer's byte is done
//            tx_data     out  [DATA_W] byte to serializer, stable between loads
//            tx_start    out  one-cycle start strobe to serializer
//            tx_busy     in   serializer busy
//            grant_id    out  [ID_W] index of current/last granted producer
//            sched_busy  out  high whenever not idle
//            timeout_err out  sticky watchdog-abort flag, cleared by reset only
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int                N_REQ       = 4,
  parameter int                ID_W        = 2,
  parameter int                DATA_W      = 8,
  parameter int                TIMEOUT_CYC = 200000,
  parameter logic [DATA_W-1:0] TAG_BASE    = 8'hA0
) (
  input  logic                      RST_clk,
  input  logic                      RST_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      sched_busy,
  output logic                      timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  // Abort on the TIMEOUT_CYC-th consecutive cycle spent waiting on the serializer.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q,   ptr_d;     // last granted index
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   hold_q,  hold_d;    // byte captured at grant
  logic [DATA_W-1:0]   txd_q,   txd_d;
  logic [WD_W-1:0]     wdog_q,  wdog_d;
  logic                terr_q,  terr_d;

  logic                w_tag_phase;        // next frame to send is the tag frame

  // --------------------------------------------------------------------------
  // Producer bytes as an array so the winner's byte is a simple index.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first set request starting just after the last grant.
  // --------------------------------------------------------------------------
  logic            w_pick_found;
  logic [ID_W-1:0] w_pick_idx;
  int              w_cand;

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = (int'(ptr_q) + k) % N_REQ;
      if (!w_pick_found && req[w_cand[ID_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand[ID_W-1:0];
      end
    end
  end

`ifdef UART_TX_SCHED_TAG_EN
  logic tag_q, tag_d;
  assign w_tag_phase = tag_q;
`else
  logic unused_tag_base;
  assign w_tag_phase     = 1'b0;
  assign unused_tag_base = ^TAG_BASE;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge RST_clk) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);   // producer 0 wins the first arbitration
      grant_q <= '0;
      hold_q  <= '0;
      txd_q   <= '0;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
      tag_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      txd_q   <= txd_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
`ifdef UART_TX_SCHED_TAG_EN
      tag_q   <= tag_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    txd_d    = txd_q;
    wdog_d   = wdog_q;
    terr_d   = terr_q;
`ifdef UART_TX_SCHED_TAG_EN
    tag_d    = tag_q;
`endif
    ack      = '0;
    tx_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_pick_found) begin
          // Pointer moves at grant, so an aborted requester drops to the
          // back of the rotation instead of monopolising the serializer.
          grant_d = w_pick_idx;
          ptr_d   = w_pick_idx;
          hold_d  = w_req_bytes[w_pick_idx];
`ifdef UART_TX_SCHED_TAG_EN
          tag_d   = 1'b1;
`endif
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
`ifdef UART_TX_SCHED_TAG_EN
        txd_d = tag_q ? (TAG_BASE | DATA_W'(grant_q)) : hold_q;
`else
        txd_d = hold_q;
`endif
        state_d = S_START;
      end

      S_START: begin
        tx_start = 1'b1;
        wdog_d   = '0;
        state_d  = S_WAIT_HI;
      end

      S_WAIT_HI, S_WAIT_LO: begin
        if (wdog_q == WD_LIMIT) begin
          terr_d  = 1'b1;
`ifdef UART_TX_SCHED_TAG_EN
          tag_d   = 1'b0;
`endif
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (state_q == S_WAIT_HI && tx_busy) begin
            state_d = S_WAIT_LO;
          end else if (state_q == S_WAIT_LO && !tx_busy) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (w_tag_phase) begin
          // Tag frame finished; the data frame follows for the same grant.
`ifdef UART_TX_SCHED_TAG_EN
          tag_d = 1'b0;
`endif
          state_d = S_LOAD;
        end else begin
          ack[grant_q] = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data     = txd_q;
  assign grant_id    = grant_q;
  assign sched_busy  = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Randomised bench for uart_tx_sched with a serializer model
//            (busy rises 2 cycles after tx_start, holds 10 cycles), a
//            round-robin reference model feeding expected frames/acks into
//            queues, and a separate monitor popping and comparing them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int         N    = 4;
  localparam int         DW   = 8;
  localparam int         IDW  = 2;
  localparam int         TO   = 50;
  localparam logic [7:0] TAGB = 8'hA0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [IDW-1:0]  grant_id;
  logic            sched_busy;
  logic            timeout_err;

  uart_tx_sched #(
    .N_REQ(N), .ID_W(IDW), .DATA_W(DW), .TIMEOUT_CYC(TO), .TAG_BASE(TAGB)
  ) dut (
    .RST_clk(clk), .RST_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int id; logic [7:0] b; } frame_t;
  frame_t exp_frames[$];
  int     exp_acks[$];

  int           model_ptr   = N - 1;
  bit           ser_dead    = 1'b0;
  bit           hold_mode   = 1'b0;
  int           hold_target = 0;
  int           acks_seen   = 0;
  logic [N-1:0] early_drop  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic void push_frames(input int id, input bit with_ack);
`ifdef UART_TX_SCHED_TAG_EN
    exp_frames.push_back('{id, TAGB | 8'(id)});
`endif
    exp_frames.push_back('{id, req_data[id*DW +: DW]});
    if (with_ack) exp_acks.push_back(id);
  endfunction

  // All requests in mask raised together while idle: served in rotation order.
  function automatic void push_round(input logic [N-1:0] mask);
    int start = model_ptr;
    for (int k = 1; k <= N; k++) begin
      int idx = (start + k) % N;
      if (mask[idx]) begin
        push_frames(idx, 1'b1);
        model_ptr = idx;
      end
    end
  endfunction

  function automatic void push_rotation(input int count);
    for (int j = 0; j < count; j++) begin
      model_ptr = (model_ptr + 1) % N;
      push_frames(model_ptr, 1'b1);
    end
  endfunction

  // ---------------- serializer model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !ser_dead) begin
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- producer behaviour ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (ack !== '0) begin
        acks_seen++;
        if (hold_mode) begin
          if (acks_seen >= hold_target) req = '0;
        end else begin
          req = req & ~ack;
        end
      end
      if (tx_start === 1'b1 && early_drop[grant_id]) req[grant_id] = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    frame_t f;
    int     id;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
        if (exp_frames.size() == 0) fail("unexpected_tx_start");
        else begin
          f = exp_frames.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, f.b});
          chk("grant_id", {30'd0, grant_id}, f.id);
        end
      end
      if (ack !== '0) begin
        if (exp_acks.size() == 0) fail("unexpected_ack");
        else begin
          id = exp_acks.pop_front();
          chk("ack", {28'd0, ack}, 32'd1 << id);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while ((exp_frames.size() != 0 || exp_acks.size() != 0 ||
            sched_busy !== 1'b0 || tx_busy !== 1'b0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) fail({name, "_timeout"});
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sig(input int budget, input bit want_busy, input string name);
    int c = 0;
    while (tx_busy !== want_busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) fail(name);
  endtask

  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] drops);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
    push_round(mask);
    early_drop = drops;
    req = mask;
    wait_done(3000, "round");
    early_drop = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int cnt;

    // Reset held 3 cycles with every producer requesting
    rst_n = 1'b0;
    req   = '1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
      chk("reset_ack", {28'd0, ack}, 32'd0);
    end
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset_grant_id", {30'd0, grant_id}, 32'd0);
    chk("reset_sched_busy", {31'd0, sched_busy}, 32'd0);
    chk("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
    model_ptr = N - 1;
    push_round(4'hF);
    rst_n = 1'b1;
    wait_done(3000, "post_reset_round");

    // Single requester, directed latency and ack timing
    req_data[2*DW +: DW] = 8'h5A;
    push_round(4'b0100);
    req = 4'b0100;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_start !== 1'b1 && lat < 10);
    chk("start_latency", lat, 32'd2);
`ifndef UART_TX_SCHED_TAG_EN
    wait_sig(30, 1'b1, "single_busy_rise");
    wait_sig(30, 1'b0, "single_busy_fall");
    @(negedge clk);
    chk("single_ack", {28'd0, ack}, 32'd4);
    chk("single_grant_id", {30'd0, grant_id}, 32'd2);
`endif
    wait_done(3000, "single");

    // Fairness: all held high, producer re-requests through its ack
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
    hold_mode   = 1'b1;
    acks_seen   = 0;
    hold_target = 8;
    push_rotation(8);
    req = 4'hF;
    wait_done(5000, "fairness");
    hold_mode = 1'b0;

    // Randomised rounds
    for (int r = 0; r < 12; r++) begin
      run_round(4'($urandom_range(1, 15)), 4'($urandom));
    end

    // Watchdog: serializer never raises busy
    ser_dead = 1'b1;
    req_data[1*DW +: DW] = 8'($urandom);
    model_ptr = 1;
    push_frames(1, 1'b0);
    early_drop = 4'b0010;
    req = 4'b0010;
    cnt = 0;
    while (tx_start !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 10) fail("timeout_no_start");
    cnt = 0;
    while (timeout_err !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt, TO + 1);
    chk("timeout_sched_idle", {31'd0, sched_busy}, 32'd0);
    ser_dead   = 1'b0;
    early_drop = '0;
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    run_round(4'($urandom_range(1, 15)), '0);
    chk("timeout_err_still_set", {31'd0, timeout_err}, 32'd1);

    // Reset during the serializer's busy window
    req_data[2*DW +: DW] = 8'($urandom);
    model_ptr = 2;
    push_frames(2, 1'b0);
    req = 4'b0100;
    wait_sig(40, 1'b1, "midframe_busy_rise");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("midreset_sched_busy", {31'd0, sched_busy}, 32'd0);
    chk("midreset_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("midreset_grant_id", {30'd0, grant_id}, 32'd0);
    chk("midreset_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    model_ptr = N - 1;
    wait_done(3000, "midreset_drain");
    run_round(4'hF, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
